// File: rtl/pkt_tx_arb_if.sv
// Bundle of the requester-side and MAC-side signals of the packet transmit arbiter.
// The err_orphan/err_cnt members exist only when PKT_TX_ARB_ERR_CHK_EN is defined.
interface pkt_tx_arb_if #(
    parameter int NUM_REQ = 2
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_val;
    logic [NUM_REQ-1:0]    req_sop;
    logic [NUM_REQ-1:0]    req_eop;
    logic [3*NUM_REQ-1:0]  req_mod;
    logic [64*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  pkt_tx_val;
    logic                  pkt_tx_sop;
    logic                  pkt_tx_eop;
    logic [2:0]            pkt_tx_mod;
    logic [63:0]           pkt_tx_data;
    logic                  pkt_tx_full;

    logic [OWN_W-1:0]      owner;
    logic                  busy;
    // Debug view of the arbiter FSM (0 = IDLE, 1 = BUSY) and round-robin pointer.
    logic                  dbg_state;
    logic [OWN_W-1:0]      dbg_rr_ptr;
`ifdef PKT_TX_ARB_ERR_CHK_EN
    logic                  err_orphan;
    logic [15:0]           err_cnt;
`endif

    // Handshake: a beat from requester i moves when req_val[i] && req_ready[i] at a rising clk.
    modport master (
        output req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
`ifdef PKT_TX_ARB_ERR_CHK_EN
        input  err_orphan, err_cnt,
`endif
        input  req_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
        input  owner, busy, dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
`ifdef PKT_TX_ARB_ERR_CHK_EN
        output err_orphan, err_cnt,
`endif
        output req_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
        output owner, busy, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/pkt_tx_arb.sv
// Packet-granular round-robin arbiter feeding one MAC transmit port; grant locked SOP..EOP.
// Optional orphan-beat dropping and error counting: define PKT_TX_ARB_ERR_CHK_EN.
module pkt_tx_arb #(
    parameter int NUM_REQ = 2
) (
    input logic         clk,
    input logic         reset_n,
    pkt_tx_arb_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_q;
    logic [OWN_W-1:0] owner_q;
    logic [OWN_W-1:0] rr_ptr_q;
    logic             busy_q;
    logic             tx_val_q;
    logic             tx_sop_q;
    logic             tx_eop_q;
    logic [2:0]       tx_mod_q;
    logic [63:0]      tx_data_q;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] ready;
    logic               win_found;
    logic [OWN_W-1:0]   win_idx;
    logic [OWN_W:0]     scan_sum;
    logic [OWN_W-1:0]   scan_idx;
    logic [OWN_W-1:0]   next_ptr;

    logic        own_val;
    logic        own_sop;
    logic        own_eop;
    logic [2:0]  own_mod;
    logic [63:0] own_data;
    logic        own_xfer;

    assign own_val  = bus.req_val[owner_q];
    assign own_sop  = bus.req_sop[owner_q];
    assign own_eop  = bus.req_eop[owner_q];
    assign own_mod  = bus.req_mod[3*int'(owner_q) +: 3];
    assign own_data = bus.req_data[64*int'(owner_q) +: 64];
    assign own_xfer = (state_q == ST_BUSY) && own_val && !bus.pkt_tx_full;

    assign next_ptr = (owner_q == OWN_W'(NUM_REQ-1)) ? '0 : owner_q + OWN_W'(1);

    // Scan starts at rr_ptr and wraps; the first candidate found wins.
    always_comb begin
        cand      = bus.req_val & bus.req_sop & {NUM_REQ{~bus.pkt_tx_full}};
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (OWN_W+1)'(k);
            if (scan_sum >= (OWN_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (OWN_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[OWN_W-1:0];
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

`ifdef PKT_TX_ARB_ERR_CHK_EN
    logic               first_q;
    logic               err_orphan_q;
    logic [15:0]        err_cnt_q;
    logic [NUM_REQ-1:0] orphan_vec;
    logic               sop_viol;
    logic               err_hit;
    logic [4:0]         err_inc;
    logic [16:0]        err_sum;
    logic [15:0]        err_cnt_d;

    // Orphan beats are only swallowed while idle; in BUSY non-owners simply wait.
    assign orphan_vec = (state_q == ST_IDLE) ? (bus.req_val & ~bus.req_sop) : '0;
    assign sop_viol   = own_xfer && own_sop && !first_q;
    assign err_hit    = (|orphan_vec) || sop_viol;
    assign err_inc    = 5'($countones(orphan_vec)) + {4'b0, sop_viol};
    assign err_sum    = {1'b0, err_cnt_q} + 17'(err_inc);
    assign err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    assign bus.err_orphan = err_orphan_q;
    assign bus.err_cnt    = err_cnt_q;
`endif

    always_comb begin
        ready = '0;
        if (state_q == ST_BUSY) begin
            ready[owner_q] = ~bus.pkt_tx_full;
        end
`ifdef PKT_TX_ARB_ERR_CHK_EN
        else begin
            ready = bus.req_val & ~bus.req_sop;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            tx_val_q  <= 1'b0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_mod_q  <= '0;
            tx_data_q <= '0;
`ifdef PKT_TX_ARB_ERR_CHK_EN
            first_q      <= 1'b0;
            err_orphan_q <= 1'b0;
            err_cnt_q    <= '0;
`endif
        end else begin
            // Control and data are zeroed on idle cycles so the MAC never sees stale beats.
            tx_val_q  <= own_xfer;
            tx_sop_q  <= own_xfer & own_sop;
            tx_eop_q  <= own_xfer & own_eop;
            tx_mod_q  <= own_xfer ? own_mod : 3'b0;
            tx_data_q <= own_xfer ? own_data : 64'b0;
`ifdef PKT_TX_ARB_ERR_CHK_EN
            err_orphan_q <= err_hit;
            err_cnt_q    <= err_cnt_d;
            if (own_xfer) begin
                first_q <= 1'b0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        owner_q <= win_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
`ifdef PKT_TX_ARB_ERR_CHK_EN
                        first_q <= 1'b1;
`endif
                    end
                end
                ST_BUSY: begin
                    if (own_xfer && own_eop) begin
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.pkt_tx_val  = tx_val_q;
    assign bus.pkt_tx_sop  = tx_sop_q;
    assign bus.pkt_tx_eop  = tx_eop_q;
    assign bus.pkt_tx_mod  = tx_mod_q;
    assign bus.pkt_tx_data = tx_data_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_rr_ptr  = rr_ptr_q;
endmodule

// File: doc/pkt_tx_arb.md
Name: pkt_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single MAC transmit packet interface (pkt_tx_*) between NUM_REQ packet sources.
- Grant is locked from SOP to EOP of a packet, so packets never interleave.
- Honours MAC backpressure via pkt_tx_full.
- Sits between testbench/traffic generators (or upstream DMA engines) and the 10G MAC transmit port.

Parameters:
- NUM_REQ, 2, number of requesters, legal range 2..8.
- OWN_W, $clog2(NUM_REQ), width of owner/pointer index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_val  input  NUM_REQ  per-requester beat valid
- req_sop  input  NUM_REQ  per-requester start of packet
- req_eop  input  NUM_REQ  per-requester end of packet
- req_mod  input  3*NUM_REQ  per-requester valid-byte modulo; slice i = [3i+2:3i]
- req_data  input  64*NUM_REQ  per-requester data; slice i = [64i+63:64i]
- req_ready  output  NUM_REQ  per-requester beat accepted (combinational)
- pkt_tx_val  output  1  beat valid to MAC
- pkt_tx_sop  output  1  start of packet to MAC
- pkt_tx_eop  output  1  end of packet to MAC
- pkt_tx_mod  output  3  valid-byte modulo to MAC
- pkt_tx_data  output  64  data to MAC
- pkt_tx_full  input  1  MAC transmit FIFO full; no new beats may be accepted while high
- owner  output  OWN_W  current grant index; meaningful only while busy=1
- busy  output  1  a packet is in progress

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer rr_ptr=0, req_ready=0.
- Transfer: beat i transfers when req_val[i] && req_ready[i].
- State IDLE:
  - req_ready all 0.
  - Candidates = req_val[i] && req_sop[i] && !pkt_tx_full.
  - Winner = first candidate scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If a winner exists: owner <= winner, busy <= 1, next state BUSY.
  - No beat is accepted in IDLE, so there is exactly one arbitration cycle per packet.
- State BUSY:
  - req_ready[owner] = !pkt_tx_full; all other req_ready = 0.
  - On an owner transfer with req_eop[owner]=1: next state IDLE, busy <= 0, rr_ptr <= owner+1 (wraps NUM_REQ-1 -> 0).
  - The owner may deassert req_val mid-packet; the grant is held indefinitely until EOP.
- Single-beat packet (sop=1 and eop=1 on the same beat): transferred in BUSY, then return to IDLE.
- Output register, latency 1 cycle:
  - pkt_tx_val <= transfer.
  - sop/eop/mod/data <= owner slice when transfer, else all 0. MAC control and data are never X while reset_n=1.
- Backpressure:
  - pkt_tx_full is sampled combinationally into req_ready.
  - The MAC full threshold must absorb the 1 in-flight registered beat.
  - pkt_tx_full high for any duration stalls the owner with no beat loss or duplication.
- Simultaneous events:
  - All requesters present SOP in the same IDLE cycle: rr_ptr decides.
  - A non-owner SOP during BUSY waits.
  - pkt_tx_full rising on an owner's EOP cycle: EOP is not accepted and is held.
- Reset mid-packet: state is cleared immediately and the MAC sees the packet truncated. The MAC shares reset_n, so no recovery is required.
- Protocol violation, SOP from the owner before EOP: forwarded unchanged; the grant stays locked until the next EOP.

Optional Feature:
- Macro: PKT_TX_ARB_ERR_CHK_EN.
- Defined:
  - In IDLE, any req_val[i] && !req_sop[i] (orphan beat) gets req_ready[i]=1. The beat is dropped and never forwarded.
  - Adds output err_orphan (1 bit, 1-cycle pulse per dropped beat).
  - Adds output err_cnt (16 bits, saturating at 0xFFFF, reset 0).
  - SOP-before-EOP from the owner also pulses err_orphan and increments err_cnt.
- Undefined:
  - Orphan beats get no ready and stall that requester.
  - The err_orphan and err_cnt ports do not exist.

Test Plan:
- Single packet, 3 beats: req 0 sends 3 beats (SOP mod=0, mid, EOP mod=5), pkt_tx_full=0 -> owner=0 after 1 arbitration cycle; MAC sees the 3 beats on consecutive cycles 1 cycle after each transfer, identical data/mod, then busy=0 and rr_ptr=1.
- Round-robin fairness: NUM_REQ=2, both requesters continuously offer 2-beat packets -> MAC packet order 0,1,0,1; each packet is contiguous and never interleaved; 1 idle cycle between packets.
- Backpressure: pkt_tx_full high for 5 cycles mid-packet (after beat 2 of 4) -> req_ready[owner]=0 for those 5 cycles; pkt_tx_val=0 for 5 cycles starting 1 cycle later; beats 3-4 delivered afterwards with no loss or duplication.
- Single-beat and simultaneous events: requesters 0 and 1 assert SOP+EOP beats in the same IDLE cycle with rr_ptr=1 -> requester 1 is granted first, then requester 0; each MAC beat has sop=eop=1.
- Async reset mid-packet: reset_n low for 2 cycles during beat 2 -> all outputs 0 immediately; state IDLE and rr_ptr=0 after release.
- With PKT_TX_ARB_ERR_CHK_EN: requester 1 asserts val with sop=0 in IDLE -> beat is dropped, err_orphan pulses once, err_cnt=1, pkt_tx_val stays 0.
- Without PKT_TX_ARB_ERR_CHK_EN: the same stimulus leaves req_ready[1]=0 indefinitely.
